// File: rtl/conv_pkg.sv
// Shared types and constants for the ping/pong line-memory scheduler.
package conv_pkg;

    // Default geometry of the line memory feeding the 3x3 conv engine
    localparam int DEF_IMAGE_SIZE  = 16;
    localparam int DEF_KERNEL_SIZE = 3;
    localparam int DEF_ADDR_SIZE   = 4;
    localparam int DEF_MAX_ADDRESS = 15;

    // Window positions along one row and rows held by one buffer
    localparam int WIN_PER_ROW   = DEF_IMAGE_SIZE - DEF_KERNEL_SIZE + 1;
    localparam int ROWS_PER_BUF  = DEF_MAX_ADDRESS + 1;
    localparam int READS_PER_BUF = WIN_PER_ROW * ROWS_PER_BUF;
    localparam int WINS_PER_BUF  = WIN_PER_ROW * (ROWS_PER_BUF - DEF_KERNEL_SIZE + 1);

    // Life cycle of one half of the line memory
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2,
        READING = 2'd3
    } buf_state_t;

    // A buffer may take loader rows only while it has not been handed to the reader
    function automatic logic is_writable(input buf_state_t s);
        return (s == EMPTY) || (s == FILLING);
    endfunction

endpackage

// File: rtl/conv_sweep_counter.sv
// Row/column sweep counter: rows run fastest, column steps on each row wrap.
module conv_sweep_counter #(
    parameter int ROW_W    = 4,
    parameter int COL_W    = 4,
    parameter int ROW_LAST = 15,
    parameter int COL_LAST = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             last
);

    localparam logic [ROW_W-1:0] ROW_END = ROW_W'(ROW_LAST);
    localparam logic [COL_W-1:0] COL_END = COL_W'(COL_LAST);

    logic [ROW_W-1:0] row_r;
    logic [COL_W-1:0] col_r;
    logic             row_end_s;
    logic             col_end_s;

    assign row_end_s = (row_r == ROW_END);
    assign col_end_s = (col_r == COL_END);

    // Nested counter state; clear wins over enable, both wrap together after the last position
    always_ff @(posedge clk) begin
        if (rst) begin
            row_r <= {ROW_W{1'b0}};
            col_r <= {COL_W{1'b0}};
        end else if (clr) begin
            row_r <= {ROW_W{1'b0}};
            col_r <= {COL_W{1'b0}};
        end else if (en) begin
            if (row_end_s) begin
                row_r <= {ROW_W{1'b0}};
                col_r <= col_end_s ? {COL_W{1'b0}} : (col_r + COL_W'(1'b1));
            end else begin
                row_r <= row_r + ROW_W'(1'b1);
            end
        end
    end

    assign row  = row_r;
    assign col  = col_r;
    assign last = row_end_s && col_end_s;

endmodule

// File: rtl/conv_pingpong_sched.sv
// Ping/pong line-memory scheduler: fills one buffer from the loader while the
// other is swept row by row for each column-window base of the conv engine.
module conv_pingpong_sched
    import conv_pkg::*;
#(
    parameter int IMAGE_SIZE  = DEF_IMAGE_SIZE,
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int ADDR_SIZE   = DEF_ADDR_SIZE,
    parameter int MAX_ADDRESS = DEF_MAX_ADDRESS,
    parameter int COL_W       = $clog2(IMAGE_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic                 out_ready,
    output logic                 ping_wr_en,
    output logic                 pong_wr_en,
    output logic [ADDR_SIZE-1:0] wr_addr,
    output logic [ADDR_SIZE-1:0] rd_addr_1,
    output logic [ADDR_SIZE-1:0] rd_addr_2,
    output logic                 rd_sel,
    output logic [COL_W-1:0]     col_base,
    output logic                 win_valid,
    output logic                 frame_done,
    output logic                 busy
);

    localparam int                   COL_LAST    = IMAGE_SIZE - KERNEL_SIZE;
    localparam logic [ADDR_SIZE-1:0] ADDR_LAST   = ADDR_SIZE'(MAX_ADDRESS);
    localparam logic [ADDR_SIZE-1:0] WIN_ROW_MIN = ADDR_SIZE'(KERNEL_SIZE - 1);

    buf_state_t           buf_state_r [2];
    buf_state_t           buf_state_s [2];
    logic                 wr_buf_r;
    logic                 wr_buf_s;
    logic                 rd_buf_r;
    logic                 rd_buf_s;
    logic [ADDR_SIZE-1:0] wr_addr_r;
    logic [ADDR_SIZE-1:0] wr_addr_s;

    logic                 load_ready_s;
    logic                 wr_fire_s;
    logic                 rd_en_s;
    logic                 sweep_clr_s;
    logic                 sweep_last_s;
    logic                 frame_done_s;
    logic [ADDR_SIZE-1:0] row_s;
    logic [COL_W-1:0]     col_s;

    logic                 win_valid_r;
    logic                 rd_sel_r;
    logic                 frame_done_r;
    logic [COL_W-1:0]     col_base_r;

    assign load_ready_s = is_writable(buf_state_r[wr_buf_r]);
    assign wr_fire_s    = load_valid && load_ready_s;
    assign rd_en_s      = (buf_state_r[rd_buf_r] == READING) && out_ready;

    conv_sweep_counter #(
        .ROW_W    (ADDR_SIZE),
        .COL_W    (COL_W),
        .ROW_LAST (MAX_ADDRESS),
        .COL_LAST (COL_LAST)
    ) u_sweep (
        .clk  (clk),
        .rst  (rst),
        .clr  (sweep_clr_s),
        .en   (rd_en_s),
        .row  (row_s),
        .col  (col_s),
        .last (sweep_last_s)
    );

    // Buffer states, buffer selectors and the row write counter
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_state_r[0] <= EMPTY;
            buf_state_r[1] <= EMPTY;
            wr_buf_r       <= 1'b0;
            rd_buf_r       <= 1'b0;
            wr_addr_r      <= {ADDR_SIZE{1'b0}};
        end else begin
            buf_state_r[0] <= buf_state_s[0];
            buf_state_r[1] <= buf_state_s[1];
            wr_buf_r       <= wr_buf_s;
            rd_buf_r       <= rd_buf_s;
            wr_addr_r      <= wr_addr_s;
        end
    end

    // Next-state logic; writer and reader never own the same buffer in a given state
    always_comb begin
        buf_state_s[0] = buf_state_r[0];
        buf_state_s[1] = buf_state_r[1];
        wr_buf_s       = wr_buf_r;
        rd_buf_s       = rd_buf_r;
        wr_addr_s      = wr_addr_r;
        sweep_clr_s    = 1'b0;
        frame_done_s   = 1'b0;

        if (wr_fire_s) begin
            if (wr_addr_r == ADDR_LAST) begin
                buf_state_s[wr_buf_r] = FULL;
                wr_addr_s             = {ADDR_SIZE{1'b0}};
                wr_buf_s              = ~wr_buf_r;
            end else begin
                buf_state_s[wr_buf_r] = FILLING;
                wr_addr_s             = wr_addr_r + ADDR_SIZE'(1'b1);
            end
        end else begin
            wr_addr_s = wr_addr_r;
        end

        case (buf_state_r[rd_buf_r])
            FULL: begin
                buf_state_s[rd_buf_r] = READING;
                sweep_clr_s           = 1'b1;
            end
            READING: begin
                if (rd_en_s && sweep_last_s) begin
                    buf_state_s[rd_buf_r] = EMPTY;
                    rd_buf_s              = ~rd_buf_r;
                    frame_done_s          = 1'b1;
                end else begin
                    buf_state_s[rd_buf_r] = READING;
                end
            end
            default: begin
                sweep_clr_s = 1'b0;
            end
        endcase
    end

    // Read-data-aligned outputs: one cycle behind the address that produced them
    always_ff @(posedge clk) begin
        if (rst) begin
            win_valid_r  <= 1'b0;
            col_base_r   <= {COL_W{1'b0}};
            rd_sel_r     <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            win_valid_r  <= rd_en_s && (row_s >= WIN_ROW_MIN);
            col_base_r   <= col_s;
            rd_sel_r     <= rd_buf_r;
            frame_done_r <= frame_done_s;
        end
    end

    assign load_ready = load_ready_s;
    assign ping_wr_en = wr_fire_s && !wr_buf_r;
    assign pong_wr_en = wr_fire_s && wr_buf_r;
    assign wr_addr    = wr_addr_r;
    assign rd_addr_1  = rd_buf_r ? {ADDR_SIZE{1'b0}} : row_s;
    assign rd_addr_2  = rd_buf_r ? row_s : {ADDR_SIZE{1'b0}};
    assign rd_sel     = rd_sel_r;
    assign col_base   = col_base_r;
    assign win_valid  = win_valid_r;
    assign frame_done = frame_done_r;
    assign busy       = (buf_state_r[0] != EMPTY) || (buf_state_r[1] != EMPTY);

endmodule

// File: doc/conv_pingpong_sched.md
Name: conv_pingpong_sched

Overview:
- Controller for the 16-bank ping/pong line memory that feeds the 3x3 convolution engine.
- Each memory word is one image row across IMAGE_SIZE banks; ping and pong each hold MAX_ADDRESS+1 rows.
- The block accepts row writes from the loader into the free buffer. It then sweeps the full buffer with read addresses and a sliding column-window base, and raises a window-valid strobe for the conv engine.
- It replaces the fixed counter-range window decode with a parameter-driven schedule.

Parameters:
IMAGE_SIZE, 16, number of banks (image columns)
KERNEL_SIZE, 3, convolution window width/height
ADDR_SIZE, 4, bank address width
MAX_ADDRESS, 15, last row address per buffer (depth-1)
COL_W, $clog2(IMAGE_SIZE), width of column-base output

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
load_valid  in  1  loader presents one row this cycle
load_ready  out  1  write buffer accepting rows
out_ready  in  1  conv engine can accept windows (throttle)
ping_wr_en  out  1  write strobe to ping half
pong_wr_en  out  1  write strobe to pong half
wr_addr  out  ADDR_SIZE  row write address
rd_addr_1  out  ADDR_SIZE  ping read address
rd_addr_2  out  ADDR_SIZE  pong read address
rd_sel  out  1  buffer whose read data is current (0 ping, 1 pong), aligned to win_valid
col_base  out  COL_W  leftmost bank of current window, aligned to win_valid
win_valid  out  1  data at banks col_base..col_base+KERNEL_SIZE-1 forms a valid window row
frame_done  out  1  one-cycle pulse when a buffer finishes reading
busy  out  1  any buffer FILLING/FULL/READING

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high.
- Reset values:
  - all outputs 0, except load_ready = 1 one cycle after reset is released;
  - both buffers EMPTY; wr_buf = ping, rd_buf = ping; all counters 0.
- Per-buffer state: EMPTY -> FILLING -> FULL -> READING -> EMPTY.
- Write side:
  - load_ready = (state[wr_buf] == EMPTY or FILLING).
  - A write happens when load_valid && load_ready. It asserts ping_wr_en or pong_wr_en (per wr_buf) combinationally in the same cycle, with wr_addr = row counter.
  - The first write moves the buffer EMPTY -> FILLING.
  - The write at wr_addr == MAX_ADDRESS moves it to FULL, clears wr_addr to 0 and toggles wr_buf.
  - load_valid while !load_ready is ignored: no strobe, no counter change.
- Read side, moving to READING:
  - When state[rd_buf] == FULL, the next cycle moves it to READING with row = 0 and col = 0.
- Read side, sweeping:
  - rd_en = READING && out_ready; counters advance only on rd_en.
  - The active rd_addr_x = row; the inactive read address is held at 0.
  - row counts 0..MAX_ADDRESS. On wrap, col increments, running 0..IMAGE_SIZE-KERNEL_SIZE.
  - The read at row == MAX_ADDRESS and col == IMAGE_SIZE-KERNEL_SIZE is the last one. It sets the buffer EMPTY, toggles rd_buf and pulses frame_done on the following cycle.
  - Reads per buffer = (IMAGE_SIZE-KERNEL_SIZE+1)*(MAX_ADDRESS+1) = 224 by default.
- Read latency is 1 cycle:
  - win_valid(t+1) = rd_en(t) && row(t) >= KERNEL_SIZE-1;
  - col_base(t+1) = col(t); rd_sel(t+1) = rd_buf(t).
  - Windows per buffer = 14*14 = 196.
- Throttle: out_ready is sampled one cycle ahead of the data. The conv engine must accept every win_valid. When out_ready = 0, addresses hold and win_valid drops the next cycle.
- Simultaneous events:
  - A write into one buffer and a read of the other proceed in the same cycle.
  - A buffer freed by the last read is writable in the next cycle (load_ready rises).
- Both FULL: the writer stalls (load_ready = 0) until rd_buf empties.
- rst mid-frame: immediate return to reset state. Partially written rows are discarded, and no frame_done is issued.
- Arithmetic: counters are unsigned and sized to hold their maximum. Comparisons use full width; there is no implicit truncation.

Decomposition:
- Shared package conv_pkg:
  - buffer-state enum buf_state_t {EMPTY, FILLING, FULL, READING};
  - localparams WIN_PER_ROW = IMAGE_SIZE-KERNEL_SIZE+1 and ROWS_PER_BUF = MAX_ADDRESS+1.
- One natural sub-module: conv_sweep_counter, the row/col nested counter with enable, last flag and wrap.

Test Plan:
- Reset checks: rst held 3 cycles then released -> load_ready = 1, win_valid = 0, busy = 0, rd_addr_1 = rd_addr_2 = 0.
- Ping fill: 16 consecutive load_valid -> ping_wr_en high 16 cycles with wr_addr 0..15. Ping becomes FULL, wr_buf = pong, and READING starts 1 cycle later with rd_addr_1 = 0.
- Full sweep: out_ready = 1 throughout -> exactly 224 reads and 196 win_valid pulses. col_base steps 0..13, and frame_done pulses once, 225 cycles after READING starts.
- Overlap: fill pong during the ping read -> pong_wr_en and rd_addr_1 are active in the same cycles. The pong read starts the cycle after ping frame_done, with rd_sel = 1 on the first pong window.
- Throttle: out_ready = 0 for 5 cycles at row 7, col 4 -> rd_addr holds 7, win_valid is low for 5 cycles, and no window is lost (total still 196).
- Both buffers full plus a reset: both full with load_valid = 1 -> load_ready = 0 until ping empties. Then assert rst at row 10 of the read -> all state clears, with no frame_done.
